// File: rtl/ad9226_capture_ctrl.sv
// Triggered burst-capture sequencer for the AD9226 sample stream: pre-trigger ring, rising-edge
// trigger, DEPTH-sample capture and oldest-first readout. Optional timeout trigger: AD9226_CAPTURE_AUTOTRIG_EN.
module ad9226_capture_ctrl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
`ifdef AD9226_CAPTURE_AUTOTRIG_EN
  , parameter int TO_W = 16
`endif
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic              ADC_VALID,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] CFG_PRE,
  input  logic [DATA_W-1:0] CFG_THRESH,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic              RD_LAST,
  output logic              BUSY,
  output logic [2:0]        STATE,
  output logic [ADDR_W-1:0] TRIG_ADDR
`ifdef AD9226_CAPTURE_AUTOTRIG_EN
  , output logic            TIMED_OUT
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(1'b0);
  localparam logic [ADDR_W:0]   DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W:0]   ZERO_L  = (ADDR_W+1)'(1'b0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARM = 3'd1, S_WAIT = 3'd2, S_POST = 3'd3, S_READ = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pre_q, pre_d, wptr_q, wptr_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d, rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]     rd_left_q, rd_left_d;
  logic [DATA_W-1:0]   thresh_q, thresh_d, prev_q, prev_d, rd_data_q, rd_data_d;
  logic                prev_vld_q, prev_vld_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic                busy_q, busy_d, we_s, crossing_s, trig_s;
  logic [DATA_W-1:0]   buf_mem [DEPTH];
`ifdef AD9226_CAPTURE_AUTOTRIG_EN
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d, to_next_s;
  logic                timed_out_q, timed_out_d, auto_s;
`endif

  assign crossing_s = ADC_VALID && prev_vld_q && (prev_q < thresh_q) && (ADC_DATA >= thresh_q);

  // Next-state and datapath control; ABORT overrides every other event.
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    thresh_d    = thresh_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    trig_addr_d = trig_addr_q;
    rd_addr_d   = rd_addr_q;
    rd_left_d   = rd_left_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    we_s        = 1'b0;
    trig_s      = 1'b0;
`ifdef AD9226_CAPTURE_AUTOTRIG_EN
    to_cnt_d    = to_cnt_q;
    timed_out_d = timed_out_q;
    to_next_s   = to_cnt_q + TO_W'(1'b1);
    auto_s      = ADC_VALID && (to_next_s == {TO_W{1'b1}}) && !crossing_s;
`endif
    if (ABORT) begin
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      cnt_d      = ZERO_A;
      rd_left_d  = ZERO_L;
      prev_vld_d = 1'b0;
`ifdef AD9226_CAPTURE_AUTOTRIG_EN
      to_cnt_d   = {TO_W{1'b0}};
`endif
    end else begin
      if ((state_q == S_ARM || state_q == S_WAIT || state_q == S_POST) && ADC_VALID) begin
        we_s       = 1'b1;
        wptr_d     = wptr_q + ONE_A;
        prev_d     = ADC_DATA;
        prev_vld_d = 1'b1;
      end else begin
        we_s = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (START) begin
            pre_d      = CFG_PRE;
            thresh_d   = CFG_THRESH;
            wptr_d     = ZERO_A;
            cnt_d      = ZERO_A;
            rd_left_d  = ZERO_L;
            prev_vld_d = 1'b0;
            state_d    = (CFG_PRE == ZERO_A) ? S_WAIT : S_ARM;
`ifdef AD9226_CAPTURE_AUTOTRIG_EN
            to_cnt_d    = {TO_W{1'b0}};
            timed_out_d = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ARM: begin
          if (ADC_VALID) begin
            cnt_d   = cnt_q + ONE_A;
            state_d = (cnt_q + ONE_A == pre_q) ? S_WAIT : S_ARM;
          end else begin
            state_d = S_ARM;
          end
        end
        S_WAIT: begin
`ifdef AD9226_CAPTURE_AUTOTRIG_EN
          trig_s = crossing_s || auto_s;
          if (auto_s) begin
            timed_out_d = 1'b1;
          end else if (ADC_VALID && !crossing_s) begin
            to_cnt_d = to_next_s;
          end else begin
            to_cnt_d = to_cnt_q;
          end
`else
          trig_s = crossing_s;
`endif
          if (trig_s) begin
            // Window starts PRE samples before the trigger; ~PRE is DEPTH-PRE-1 post samples.
            trig_addr_d = wptr_q;
            rd_addr_d   = wptr_q - pre_q;
            rd_left_d   = DEPTH_L;
            cnt_d       = ~pre_q;
            state_d     = (~pre_q == ZERO_A) ? S_READ : S_POST;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_POST: begin
          if (ADC_VALID) begin
            cnt_d   = cnt_q - ONE_A;
            state_d = (cnt_q == ONE_A) ? S_READ : S_POST;
          end else begin
            state_d = S_POST;
          end
        end
        S_READ: begin
          if (rd_valid_q && RD_READY && rd_last_q) begin
            state_d    = S_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end else if (rd_left_q != ZERO_L && (!rd_valid_q || RD_READY)) begin
            // Output register doubles as the RAM read register, giving prefetch at full rate.
            rd_data_d  = buf_mem[rd_addr_q];
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_left_q == ONE_L);
            rd_addr_d  = rd_addr_q + ONE_A;
            rd_left_d  = rd_left_q - ONE_L;
          end else if (rd_valid_q && RD_READY) begin
            rd_valid_d = 1'b0;
          end else begin
            rd_valid_d = rd_valid_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // Sample buffer write port; contents need no reset.
  always_ff @(posedge CLOCK) begin
    if (we_s) begin
      buf_mem[wptr_q] <= ADC_DATA;
    end
  end

  // Control and output registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      pre_q       <= ZERO_A;
      thresh_q    <= {DATA_W{1'b0}};
      wptr_q      <= ZERO_A;
      cnt_q       <= ZERO_A;
      prev_q      <= {DATA_W{1'b0}};
      prev_vld_q  <= 1'b0;
      trig_addr_q <= ZERO_A;
      rd_addr_q   <= ZERO_A;
      rd_left_q   <= ZERO_L;
      rd_data_q   <= {DATA_W{1'b0}};
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AD9226_CAPTURE_AUTOTRIG_EN
      to_cnt_q    <= {TO_W{1'b0}};
      timed_out_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      thresh_q    <= thresh_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      trig_addr_q <= trig_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
`ifdef AD9226_CAPTURE_AUTOTRIG_EN
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
`endif
    end
  end

  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_LAST   = rd_last_q;
  assign BUSY      = busy_q;
  assign STATE     = state_q;
  assign TRIG_ADDR = trig_addr_q;
`ifdef AD9226_CAPTURE_AUTOTRIG_EN
  assign TIMED_OUT = timed_out_q;
`endif

endmodule

// File: tb/tb_ad9226_capture_ctrl.sv
// Directed bench for ad9226_capture_ctrl with DEPTH=16: table of ramp captures plus
// hand-written sequences for constant input, ignored START, ABORT and async reset.
module tb_ad9226_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] adc_data;
  logic        adc_valid, start, abort_i, rd_ready;
  logic [3:0]  cfg_pre;
  logic [11:0] cfg_thresh;
  logic [11:0] rd_data;
  logic        rd_valid, rd_last, busy;
  logic [2:0]  state;
  logic [3:0]  trig_addr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_arr [16];

  typedef struct {
    logic [3:0]  pre;
    logic [11:0] thr;
    bit          stall;
    logic [11:0] first;
    logic [3:0]  trig;
  } cap_vec_t;

  cap_vec_t vecs [4];

  ad9226_capture_ctrl #(.DATA_W(12), .ADDR_W(4)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .ADC_DATA(adc_data), .ADC_VALID(adc_valid),
    .START(start), .ABORT(abort_i), .CFG_PRE(cfg_pre), .CFG_THRESH(cfg_thresh),
    .RD_DATA(rd_data), .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_LAST(rd_last),
    .BUSY(busy), .STATE(state), .TRIG_ADDR(trig_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Start a capture and drive a ramp 0,1,2,... until READ is reached.
  task automatic capture_ramp(input logic [3:0] pre, input logic [11:0] thr, input int stop_state);
    int k;
    start = 1'b1; cfg_pre = pre; cfg_thresh = thr; adc_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("arm_state", state, (pre == 4'd0) ? 2 : 1);
    check("arm_busy", busy, 1);
    adc_valid = 1'b1; adc_data = 12'd0; k = 0;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      if (state == stop_state[2:0]) break;
      k++;
      adc_data = k[11:0];
    end
    check("capture_reaches_state", state, stop_state);
  endtask

  // Consume 16 samples, optionally stalling, checking order, RD_LAST and stall stability.
  task automatic readout(input bit stall);
    int idx = 0;
    bit st = 1'b0, done = 1'b0, seen = 1'b0;
    logic [11:0] hd = 12'd0;
    logic hl = 1'b0;
    adc_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (rd_valid) seen = 1'b1;
      if (cyc == 2) check("valid_latency", seen, 1);
      if (st) begin
        check("stall_valid", rd_valid, 1);
        check("stall_data", rd_data, hd);
        check("stall_last", rd_last, hl);
      end
      rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      st = rd_valid && !rd_ready;
      hd = rd_data; hl = rd_last;
      if (rd_valid && rd_ready) begin
        check("rd_data", rd_data, exp_arr[idx]);
        check("rd_last", rd_last, (idx == 15) ? 1 : 0);
        if (idx == 15) done = 1'b1;
        idx++;
      end
      @(negedge clk);
    end
    check("readout_complete", done, 1);
    rd_ready = 1'b0;
    check("post_read_state", state, 0);
    check("post_read_valid", rd_valid, 0);
    check("post_read_busy", busy, 0);
  endtask

  initial begin
    vecs[0] = '{pre: 4'd2,  thr: 12'd20,  stall: 1'b1, first: 12'd18, trig: 4'd4};
    vecs[1] = '{pre: 4'd4,  thr: 12'd100, stall: 1'b0, first: 12'd96, trig: 4'd4};
    vecs[2] = '{pre: 4'd0,  thr: 12'd50,  stall: 1'b0, first: 12'd50, trig: 4'd2};
    vecs[3] = '{pre: 4'd15, thr: 12'd30,  stall: 1'b1, first: 12'd15, trig: 4'd14};

    rst_n = 1'b0; adc_data = 12'd0; adc_valid = 1'b0; start = 1'b0; abort_i = 1'b0;
    rd_ready = 1'b0; cfg_pre = 4'd0; cfg_thresh = 12'd0;
    @(negedge clk); @(negedge clk);
    check("reset_state", state, 0);
    check("reset_busy", busy, 0);
    check("reset_valid", rd_valid, 0);
    check("reset_last", rd_last, 0);
    check("reset_data", rd_data, 0);
    check("reset_trig", trig_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // START together with ABORT in IDLE is dropped.
    start = 1'b1; abort_i = 1'b1; cfg_pre = 4'd3; cfg_thresh = 12'd5;
    @(negedge clk);
    start = 1'b0; abort_i = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_state", state, 0);

    // ABORT in POST after three post-trigger samples.
    capture_ramp(4'd4, 12'd100, 3);
    check("abort_seq_trig", trig_addr, 4);
    for (int i = 101; i <= 103; i++) begin
      adc_data = i[11:0];
      @(negedge clk);
    end
    check("post_after_3", state, 3);
    adc_data = 12'd104; abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; adc_valid = 1'b0;
    check("abort_state", state, 0);
    check("abort_valid", rd_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_trig_held", trig_addr, 4);

    // Table-driven ramp captures (first entry is the PRE=2 restart after abort).
    for (int v = 0; v < 4; v++) begin
      capture_ramp(vecs[v].pre, vecs[v].thr, 4);
      check("trig_addr", trig_addr, vecs[v].trig);
      for (int i = 0; i < 16; i++) exp_arr[i] = vecs[v].first + 12'(i);
      readout(vecs[v].stall);
    end

    // Constant level above threshold, ignored START in WAIT_TRIG, then a real crossing.
    start = 1'b1; cfg_pre = 4'd4; cfg_thresh = 12'd100;
    @(negedge clk);
    start = 1'b0; adc_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      adc_data = 12'd200;
      if (i == 500) begin
        start = 1'b1; cfg_pre = 4'd0; cfg_thresh = 12'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("const_wait", state, 2);
    adc_data = 12'd10;
    @(negedge clk);
    check("low_sample_wait", state, 2);
    adc_data = 12'd150;
    @(negedge clk);
    check("cross_post", state, 3);
    check("cross_trig_addr", trig_addr, 1001 % 16);
    for (int i = 151; i < 200; i++) begin
      if (state == 3'd4) break;
      adc_data = i[11:0];
      @(negedge clk);
    end
    check("const_read", state, 4);
    for (int i = 0; i < 3; i++) exp_arr[i] = 12'd200;
    exp_arr[3] = 12'd10;
    for (int i = 4; i < 16; i++) exp_arr[i] = 12'd146 + 12'(i);
    readout(1'b0);

    // Async reset during readout.
    capture_ramp(4'd4, 12'd100, 4);
    adc_valid = 1'b0; rd_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("mid_read_valid", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_valid", rd_valid, 0);
    check("async_rst_last", rd_last, 0);
    check("async_rst_data", rd_data, 0);
    check("async_rst_busy", busy, 0);
    rd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_state", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
